irq_controller: RTL and testbench
=================================

// Module: irq_controller
// PURPOSE
//  Interrupt controller consuming the timer's expiry/overflow pulse plus other peripheral IRQ lines.
//  Latches requests into a pending register and masks them with an enable register.
//  Presents one fixed-priority request to the CPU with an ack/end-of-interrupt handshake.
//  Memory-mapped on the device bus next to the timer; the CPU reads and clears state over that bus.
// PARAMETERS
//  NUM_SOURCES  8   number of IRQ inputs; bit 0 = timer, lowest index = highest priority
//  ID_WIDTH     3   width of irqId; must satisfy 2**ID_WIDTH >= NUM_SOURCES
// PORTS
//  clk         in   1            system clock
//  reset       in   1            asynchronous, active-high reset
//  chipSelect  in   1            bus select for this device
//  write       in   1            bus write strobe; qualified by chipSelect
//  address     in   2            register select
//  dataIn      in   32           bus write data
//  dataOut     out  32           bus read data; 0 when chipSelect=0
//  irqSources  in   NUM_SOURCES  request lines, synchronous to clk
//  irqOut      out  1            interrupt request to CPU
//  irqId       out  ID_WIDTH     id of the requested/in-service source
//  irqAck      in   1            CPU accepts the request (1-cycle pulse)
// BEHAVIOUR
//  Registers: addr0 PENDING (R; write 1 to clear); addr1 ENABLE (R/W); addr2 ACTIVE
//   (R: {valid@bit31, id}; W: EOI, dataIn[ID_WIDTH-1:0]=id); addr3 CTRL (bit0 global enable, R/W).
//  Bits above NUM_SOURCES read 0 and ignore writes. Reads are combinational on address.
//  Reset: pending=0, enable=0, globalEn=0, state=IDLE, irqOut=0, irqId=0; dataOut=0.
//  Pending set: request seen at edge N -> pending bit 1 after edge N (see CONFIGURATION).
//  Set and W1C on the same bit in the same cycle: set wins.
//  FSM:
//   IDLE: if globalEn && |(pending & enable): latch lowest-index winner into irqId -> REQUEST.
//   REQUEST: irqOut=1. irqAck -> clear pending[irqId], -> SERVICE (irqOut=0 next cycle).
//    If pending[irqId]&enable[irqId] or globalEn drops before ack -> IDLE, irqOut=0 next cycle.
//    Higher-priority arrival during REQUEST does not preempt; irqId stays stable.
//   SERVICE: irqOut=0, ACTIVE.valid=1. EOI write with matching id -> IDLE.
//    EOI with non-matching id ignored. New pending bits accumulate; no nesting.
//  irqAck outside REQUEST ignored. EOI outside SERVICE ignored.
//  Earliest re-request after EOI: EOI edge -> IDLE, next edge -> REQUEST (2 cycles).
//  Async reset mid-REQUEST/SERVICE: immediate return to reset values; pending lost.
// CONFIGURATION
//  IRQ_CTRL_EDGE_DETECT_EN defined: per-source previous-value flop; pending set on 0->1
//   transition only; a held-high line sets pending once; W1C clears permanently.
//  Not defined: level-sensitive; pending set every cycle the line is high; W1C or ack clears
//   only if line is low by the next cycle, else bit re-sets. No previous-value flops built.
// STRUCTURE
//  Package irq_ctrl_pkg: state enum (IDLE, REQUEST, SERVICE), register address constants
//   (ADDR_PENDING=0, ADDR_ENABLE=1, ADDR_ACTIVE=2, ADDR_CTRL=3), ACTIVE valid bit index 31.
//  Sub-module irq_priority_encoder: combinational, NUM_SOURCES vector -> {any, lowest index}.
// TESTING
//  1 Reset, enable=0x01, CTRL=1, pulse irqSources[0] 1 cycle -> pending=0x01 next cycle,
//    irqOut=1 one cycle later, irqId=0.
//  2 Sources 3 and 5 pulsed same cycle, enable=0xFF -> irqId=3; ack -> pending=0x20,
//    ACTIVE=0x80000003; EOI id 3 -> IDLE, 2 cycles later irqOut=1, irqId=5.
//  3 In REQUEST for id 2 write ENABLE=0 -> irqOut=0 next cycle, state IDLE, pending[2] still 1.
//  4 In SERVICE id 0 write EOI id 1 -> ACTIVE stays 0x80000000; EOI id 0 -> ACTIVE=0.
//  5 Source 4 rises same cycle as W1C of bit 4 -> pending[4]=1; edge build: held-high
//    source 4 after W1C stays 0; level build: re-sets to 1.
//  6 Assert reset while irqOut=1 -> irqOut=0, pending=0, dataOut=0 without a clock edge.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared types and register map for the interrupt controller.
package irq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  localparam logic [1:0] ADDR_PENDING = 2'd0;
  localparam logic [1:0] ADDR_ENABLE  = 2'd1;
  localparam logic [1:0] ADDR_ACTIVE  = 2'd2;
  localparam logic [1:0] ADDR_CTRL    = 2'd3;

  localparam int ACTIVE_VALID_BIT = 31;

endpackage

// File: rtl/irq_priority_encoder.sv
// Fixed-priority encoder: lowest set index wins; any_o flags a non-empty vector.
module irq_priority_encoder
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_SOURCES = 8,
  parameter int ID_WIDTH    = 3
) (
  input  logic [NUM_SOURCES-1:0] req_i,
  output logic                   any_o,
  output logic [ID_WIDTH-1:0]    idx_o
);

  always_comb begin
    any_o = |req_i;
    idx_o = '0;
    // Scan downwards so the last hit, the lowest index, is the one kept.
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = ID_WIDTH'(i);
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller with pending/enable registers, fixed priority and ack/EOI handshake.
// Define IRQ_CTRL_EDGE_DETECT_EN for rising-edge capture; default build is level-sensitive.
module irq_controller
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_SOURCES = 8,
  parameter int ID_WIDTH    = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   chipSelect,
  input  logic                   write,
  input  logic [1:0]             address,
  input  logic [31:0]            dataIn,
  output logic [31:0]            dataOut,
  input  logic [NUM_SOURCES-1:0] irqSources,
  output logic                   irqOut,
  output logic [ID_WIDTH-1:0]    irqId,
  input  logic                   irqAck,
  output irq_state_e             dbg_state_o
);

  // Handshake: irqOut stays high for every cycle in REQUEST; a single-cycle irqAck
  // sampled while irqOut is high accepts irqId. Ack at any other time is ignored.

  irq_state_e             state_q, state_d;
  logic [NUM_SOURCES-1:0] pending_q, pending_d;
  logic [NUM_SOURCES-1:0] enable_q, enable_d;
  logic                   global_en_q, global_en_d;
  logic [ID_WIDTH-1:0]    irq_id_q, irq_id_d;

  logic [NUM_SOURCES-1:0] set_vec, clr_vec;
  logic                   win_any;
  logic [ID_WIDTH-1:0]    win_id;
  logic                   bus_wr, eoi_hit;
  logic                   unused_data;

  assign bus_wr      = chipSelect & write;
  // Data bits above the implemented sources have no storage behind them.
  assign unused_data = ^dataIn;

`ifdef IRQ_CTRL_EDGE_DETECT_EN
  logic [NUM_SOURCES-1:0] src_prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) src_prev_q <= '0;
    else       src_prev_q <= irqSources;
  end

  assign set_vec = irqSources & ~src_prev_q;
`else
  assign set_vec = irqSources;
`endif

  always_comb begin
    clr_vec = '0;
    if (bus_wr && address == ADDR_PENDING) clr_vec = dataIn[NUM_SOURCES-1:0];
    if (state_q == REQUEST && irqAck) clr_vec[irq_id_q] = 1'b1;
    // A set in the same cycle as a clear wins.
    pending_d = (pending_q & ~clr_vec) | set_vec;

    enable_d = enable_q;
    if (bus_wr && address == ADDR_ENABLE) enable_d = dataIn[NUM_SOURCES-1:0];

    global_en_d = global_en_q;
    if (bus_wr && address == ADDR_CTRL) global_en_d = dataIn[0];
  end

  irq_priority_encoder #(
    .NUM_SOURCES(NUM_SOURCES),
    .ID_WIDTH   (ID_WIDTH)
  ) u_prio (
    .req_i(pending_q & enable_q),
    .any_o(win_any),
    .idx_o(win_id)
  );

  assign eoi_hit = bus_wr && address == ADDR_ACTIVE && dataIn[ID_WIDTH-1:0] == irq_id_q;

  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    irqOut   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (global_en_q && win_any) begin
          irq_id_d = win_id;
          state_d  = REQUEST;
        end
      end
      REQUEST: begin
        irqOut = 1'b1;
        // Withdraw on the same edge that removes the request, unless it was just accepted.
        if (irqAck) state_d = SERVICE;
        else if (!(pending_d[irq_id_q] && enable_d[irq_id_q] && global_en_d)) state_d = IDLE;
      end
      SERVICE: begin
        if (eoi_hit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      enable_q    <= '0;
      global_en_q <= 1'b0;
      irq_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      enable_q    <= enable_d;
      global_en_q <= global_en_d;
      irq_id_q    <= irq_id_d;
    end
  end

  always_comb begin
    dataOut = '0;
    if (chipSelect) begin
      unique case (address)
        ADDR_PENDING: dataOut = 32'(pending_q);
        ADDR_ENABLE:  dataOut = 32'(enable_q);
        ADDR_ACTIVE: begin
          if (state_q == SERVICE) begin
            dataOut[ID_WIDTH-1:0]     = irq_id_q;
            dataOut[ACTIVE_VALID_BIT] = 1'b1;
          end
        end
        default:      dataOut[0] = global_en_q;
      endcase
    end
  end

  assign irqId       = irq_id_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed plus randomized bench for irq_controller against a behavioural model.
module tb_irq_controller;
  import irq_ctrl_pkg::*;

  localparam int NS = 8;
  localparam int IW = 3;
`ifdef IRQ_CTRL_EDGE_DETECT_EN
  localparam bit EDGE_MODE = 1'b1;
`else
  localparam bit EDGE_MODE = 1'b0;
`endif

  localparam int M_IDLE = 0;
  localparam int M_REQ  = 1;
  localparam int M_SVC  = 2;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic          cs    = 1'b0;
  logic          we    = 1'b0;
  logic          ack   = 1'b0;
  logic [1:0]    addr  = 2'd0;
  logic [31:0]   din   = 32'd0;
  logic [NS-1:0] src   = '0;
  logic [31:0]   dout;
  logic          irq_out;
  logic [IW-1:0] irq_id;
  irq_state_e    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [NS-1:0] m_pend, m_en, m_prev;
  logic          m_gen;
  logic [IW-1:0] m_id;
  int            m_mode;

  always #5 clk = ~clk;

  irq_controller #(.NUM_SOURCES(NS), .ID_WIDTH(IW)) dut (
    .clk        (clk),
    .reset      (reset),
    .chipSelect (cs),
    .write      (we),
    .address    (addr),
    .dataIn     (din),
    .dataOut    (dout),
    .irqSources (src),
    .irqOut     (irq_out),
    .irqId      (irq_id),
    .irqAck     (ack),
    .dbg_state_o(dbg_state)
  );

  function automatic logic [IW-1:0] lowest(input logic [NS-1:0] v);
    logic [NS-1:0] iso;
    iso = v & (~v + 1'b1);
    return IW'($clog2(iso));
  endfunction

  function automatic logic [31:0] model_reg(input logic [1:0] a);
    case (a)
      2'd0:    return 32'(m_pend);
      2'd1:    return 32'(m_en);
      2'd2:    return (m_mode == M_SVC) ? (32'h8000_0000 | 32'(m_id)) : 32'h0;
      default: return {31'h0, m_gen};
    endcase
  endfunction

  function automatic irq_state_e exp_state();
    case (m_mode)
      M_REQ:   return REQUEST;
      M_SVC:   return SERVICE;
      default: return IDLE;
    endcase
  endfunction

  task automatic model_reset();
    m_pend = '0; m_en = '0; m_prev = '0; m_gen = 1'b0; m_id = '0; m_mode = M_IDLE;
  endtask

  // Applies one clock of the controller's rules to the model using the inputs now driven.
  task automatic model_step();
    logic [NS-1:0] set_m, clr_m, n_pend, n_en;
    logic          n_gen, wr;
    wr    = cs & we;
    set_m = EDGE_MODE ? (src & ~m_prev) : src;
    clr_m = (wr && addr == 2'd0) ? din[NS-1:0] : '0;
    if (m_mode == M_REQ && ack) clr_m = clr_m | NS'(1 << m_id);
    n_pend = (m_pend & ~clr_m) | set_m;
    n_en   = (wr && addr == 2'd1) ? din[NS-1:0] : m_en;
    n_gen  = (wr && addr == 2'd3) ? din[0] : m_gen;
    if (m_mode == M_IDLE) begin
      if (m_gen && (m_pend & m_en) != '0) begin
        m_id   = lowest(m_pend & m_en);
        m_mode = M_REQ;
      end
    end else if (m_mode == M_REQ) begin
      if (ack) m_mode = M_SVC;
      else if (!(n_pend[m_id] && n_en[m_id] && n_gen)) m_mode = M_IDLE;
    end else begin
      if (wr && addr == 2'd2 && din[IW-1:0] == m_id) m_mode = M_IDLE;
    end
    m_pend = n_pend; m_en = n_en; m_gen = n_gen; m_prev = src;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs();
    chk("irq_out", 32'(irq_out), 32'(m_mode == M_REQ));
    chk("irq_id", 32'(irq_id), 32'(m_id));
    chk("state", 32'(dbg_state), 32'(exp_state()));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cs = 1'b0; we = 1'b0; ack = 1'b0; addr = 2'd0; din = 32'd0;
    chk_outputs();
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    cs = 1'b1; we = 1'b1; addr = a; din = d;
    tick();
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a);
    cs = 1'b1; we = 1'b0; addr = a;
    #1;
    chk(tag, dout, model_reg(a));
    cs = 1'b0;
  endtask

  task automatic rd_const(input string tag, input logic [1:0] a, input logic [31:0] exp);
    cs = 1'b1; we = 1'b0; addr = a;
    #1;
    chk(tag, dout, exp);
    cs = 1'b0;
  endtask

  initial begin
    model_reset();
    // Reset state.
    @(posedge clk);
    #1;
    chk("rst_irq_out", 32'(irq_out), 32'h0);
    chk("rst_irq_id", 32'(irq_id), 32'h0);
    chk("rst_dout_nocs", dout, 32'h0);
    for (int a = 0; a < 4; a++) rd_const("rst_reg", 2'(a), 32'h0);
    reset = 1'b0;
    tick();

    // Single timer pulse, latency to irqOut.
    bus_wr(ADDR_ENABLE, 32'h01);
    bus_wr(ADDR_CTRL, 32'h1);
    src = 8'h01;
    tick();
    src = '0;
    rd_const("t1_pend", ADDR_PENDING, 32'h01);
    chk("t1_no_irq_yet", 32'(irq_out), 32'h0);
    tick();
    chk("t1_irq_out", 32'(irq_out), 32'h1);
    chk("t1_irq_id", 32'(irq_id), 32'h0);
    ack = 1'b1;
    tick();
    bus_wr(ADDR_ACTIVE, 32'h0);

    // Two sources together: priority, ack, EOI, re-request.
    bus_wr(ADDR_ENABLE, 32'hFF);
    src = 8'h28;
    tick();
    src = '0;
    tick();
    chk("t2_irq_id3", 32'(irq_id), 32'h3);
    ack = 1'b1;
    tick();
    rd_const("t2_pend", ADDR_PENDING, 32'h20);
    rd_const("t2_active", ADDR_ACTIVE, 32'h8000_0003);
    bus_wr(ADDR_ACTIVE, 32'h3);
    chk("t2_eoi_out", 32'(irq_out), 32'h0);
    tick();
    chk("t2_rereq_out", 32'(irq_out), 32'h1);
    chk("t2_rereq_id5", 32'(irq_id), 32'h5);
    ack = 1'b1;
    tick();
    bus_wr(ADDR_ACTIVE, 32'h5);

    // Disable while requesting withdraws the request, pending survives.
    src = 8'h04;
    tick();
    src = '0;
    tick();
    chk("t3_req_id2", 32'(irq_id), 32'h2);
    bus_wr(ADDR_ENABLE, 32'h0);
    chk("t3_withdraw", 32'(irq_out), 32'h0);
    rd_const("t3_pend", ADDR_PENDING, 32'h04);
    bus_wr(ADDR_PENDING, 32'h04);
    bus_wr(ADDR_ENABLE, 32'hFF);

    // EOI with wrong id is ignored.
    src = 8'h01;
    tick();
    src = '0;
    tick();
    ack = 1'b1;
    tick();
    bus_wr(ADDR_ACTIVE, 32'h1);
    rd_const("t4_active_kept", ADDR_ACTIVE, 32'h8000_0000);
    bus_wr(ADDR_ACTIVE, 32'h0);
    rd_const("t4_active_clr", ADDR_ACTIVE, 32'h0);

    // Set versus W1C collision, then W1C with the line held high.
    bus_wr(ADDR_ENABLE, 32'h0);
    src = 8'h10;
    bus_wr(ADDR_PENDING, 32'h10);
    rd_const("t5_set_wins", ADDR_PENDING, 32'h10);
    bus_wr(ADDR_PENDING, 32'h10);
    rd_const("t5_held_w1c", ADDR_PENDING, EDGE_MODE ? 32'h0 : 32'h10);
    src = '0;
    bus_wr(ADDR_PENDING, 32'h10);
    rd_chk("t5_cleared", ADDR_PENDING);

    // Randomized traffic.
    bus_wr(ADDR_ENABLE, 32'hFF);
    bus_wr(ADDR_CTRL, 32'h1);
    for (int i = 0; i < 400; i++) begin
      src = ($urandom_range(0, 3) == 0) ? (NS'($urandom) & NS'($urandom)) : '0;
      ack = (irq_out && $urandom_range(0, 2) == 0) || ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) begin
        cs = 1'b1; we = 1'b1;
        case ($urandom_range(0, 7))
          0, 1, 2: begin
            addr = ADDR_ACTIVE;
            din  = ($urandom_range(0, 1) == 0) ? 32'(m_id) : $urandom;
          end
          3, 4: begin addr = ADDR_PENDING; din = $urandom; end
          5, 6: begin addr = ADDR_ENABLE; din = $urandom | 32'h1; end
          default: begin addr = ADDR_CTRL; din = 32'($urandom_range(0, 3) != 0); end
        endcase
      end
      tick();
      rd_chk("rand_rd", 2'($urandom_range(0, 3)));
    end

    // Async reset while requesting.
    src = '0;
    bus_wr(ADDR_CTRL, 32'h0);
    if (m_mode == M_SVC) bus_wr(ADDR_ACTIVE, 32'(m_id));
    bus_wr(ADDR_PENDING, 32'hFF);
    bus_wr(ADDR_ENABLE, 32'hFF);
    bus_wr(ADDR_CTRL, 32'h1);
    src = 8'h02;
    tick();
    src = '0;
    tick();
    chk("t6_req_out", 32'(irq_out), 32'h1);
    cs = 1'b1; we = 1'b0; addr = ADDR_PENDING;
    #1;
    chk("t6_pend_before", dout, 32'h02);
    reset = 1'b1;
    #1;
    chk("t6_rst_irq_out", 32'(irq_out), 32'h0);
    chk("t6_rst_dout", dout, 32'h0);
    chk("t6_rst_irq_id", 32'(irq_id), 32'h0);
    chk("t6_rst_state", 32'(dbg_state), 32'(IDLE));
    model_reset();
    cs = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    rd_chk("t6_post_pend", ADDR_PENDING);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
